// File: rtl/instr_encoder_loader_pkg.sv
// Shared types, opcodes and instruction field positions for the program loader.
package instr_encoder_loader_pkg;

  // Field-level instruction formats accepted by the encoder.
  typedef enum logic [2:0] {
    FMT_R      = 3'd0,
    FMT_IMM    = 3'd1,
    FMT_STORE  = 3'd2,
    FMT_BRANCH = 3'd3,
    FMT_UPPER  = 3'd4,
    FMT_JUMP   = 3'd5
  } instr_format_t;

  // RV32I major opcodes.
  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_REG    = 7'b0110011
  } opcode_t;

  // Load session state; exposed on the debug port.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } load_state_t;

  // Bit positions of the fixed fields inside an encoded word.
  localparam int RD_LSB  = 7;
  localparam int F3_LSB  = 12;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam int F7_LSB  = 25;

  // funct3 values that turn OP-IMM into a shift (SLLI, SRLI/SRAI).
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SRX = 3'b101;

  // True when v is representable as an n-bit two's complement value.
  function automatic logic fits_signed(input logic [31:0] v, input int n);
    logic [31:0] mag;
    mag = v[31] ? ~v : v;
    return (mag >> (n - 1)) == 32'd0;
  endfunction

endpackage

// File: rtl/instr_encoder_loader_fifo.sv
// Synchronous 32-bit FIFO holding encoded words between encoder and memory.
module instr_fifo
  import instr_encoder_loader_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_flush,
  input  logic        i_push,
  input  logic        i_pop,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_full,
  output logic        o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_rdata   = r_mem[r_rptr];

  // Storage array; written only on an accepted push.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_wdata;
  end

  // Pointers and occupancy; flush empties the buffer in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + (AW+1)'(1);
      else if (w_do_pop && !w_do_push) r_count <= r_count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: packs field-level instructions into RV32I words, buffers them
// and writes them to consecutive instruction memory addresses.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high (in_valid/in_ready on input, mem_we/mem_ready on the memory side); the
// offering side holds its payload stable until then, and ready never depends
// combinationally on the same side's valid.
module instr_encoder_loader
  import instr_encoder_loader_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic                  load_end,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  instr_format_t         in_fmt,
  input  logic [6:0]            in_opcode,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  input  logic [2:0]            in_funct3,
  input  logic [6:0]            in_funct7,
  input  logic [31:0]           in_imm,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] words_written,
  output logic                  err,
  output logic                  busy,
  output logic                  done,
  output load_state_t           dbg_state
);

  load_state_t           r_state;
  load_state_t           w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_count;
  logic                  r_err;
  logic [31:0]           w_enc;
  logic [31:0]           w_head;
  logic                  w_ok;
  logic                  w_is_shift;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_in_ready;
  logic                  w_accept;
  logic                  w_push;
  logic                  w_pop;

  // Inputs are accepted only while loading; the load_start cycle is a flush cycle.
  assign w_in_ready = (r_state == ST_LOAD) && !w_full && !load_start;
  assign w_accept   = in_valid && w_in_ready;
  assign w_push     = w_accept && w_ok;
  assign w_pop      = !w_empty && mem_ready && !load_start;
  assign w_is_shift = (in_opcode == OP_IMM) &&
                      ((in_funct3 == F3_SLL) || (in_funct3 == F3_SRX));

  // Encoder mux and immediate range checker.
  always_comb begin
    w_enc = '0;
    w_ok  = 1'b1;
    case (in_fmt)
      FMT_R: w_enc = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      FMT_IMM: begin
        if (w_is_shift) begin
          w_enc = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_opcode};
          w_ok  = (in_imm[31:5] == 27'd0);
        end else begin
          w_enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
          w_ok  = fits_signed(in_imm, 12);
        end
      end
      FMT_STORE: begin
        w_enc = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        w_ok  = fits_signed(in_imm, 12);
      end
      FMT_BRANCH: begin
        w_enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                 in_imm[4:1], in_imm[11], in_opcode};
        w_ok  = fits_signed(in_imm, 13) && !in_imm[0];
      end
      FMT_UPPER: begin
        w_enc = {in_imm[31:12], in_rd, in_opcode};
        w_ok  = (in_imm[11:0] == 12'd0);
      end
      FMT_JUMP: begin
        w_enc = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        w_ok  = fits_signed(in_imm, 21) && !in_imm[0];
      end
      default: w_ok = 1'b0;
    endcase
  end

  instr_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (load_start),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_enc),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Session state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic; load_start restarts a session from any state.
  always_comb begin
    w_next = r_state;
    if (load_start) begin
      w_next = ST_LOAD;
    end else begin
      case (r_state)
        ST_LOAD:  if (load_end) w_next = ST_DRAIN;
        ST_DRAIN: if (w_empty)  w_next = ST_DONE;
        default:  w_next = r_state;
      endcase
    end
  end

  // Write address, completed-write count and sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= BASE_ADDR;
      r_count <= '0;
      r_err   <= 1'b0;
    end else if (load_start) begin
      r_addr  <= BASE_ADDR;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_pop) begin
        r_addr  <= r_addr + ADDR_WIDTH'(4);
        r_count <= r_count + ADDR_WIDTH'(1);
      end
      if (w_accept && !w_ok) r_err <= 1'b1;
    end
  end

  assign in_ready      = w_in_ready;
  assign mem_we        = !w_empty;
  assign mem_wdata     = w_head;
  assign mem_addr      = r_addr;
  assign words_written = r_count;
  assign err           = r_err;
  assign busy          = (r_state == ST_LOAD) || (r_state == ST_DRAIN);
  assign done          = (r_state == ST_DONE);
  assign dbg_state     = r_state;

endmodule
